// File: rtl/puf_frame_tx.sv
//==============================================================================
// Module      : puf_frame_tx
// Description : Serialises a captured PUF response frame onto an idle-high
//               line as start bit, LSB-first payload (normal or debug
//               length), even parity bit and stop bit, paced by bit_tick.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module puf_frame_tx #(
  parameter int FRAM_SIZE = 160,
  parameter int NORM_MOD  = 34,
  parameter int DEBUG_MOD = 133,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [FRAM_SIZE-1:0] frame_data,
  input  logic                 debug_mode,
  input  logic                 bit_tick,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  // Index of the final payload bit for each frame flavour.
  localparam logic [CNT_W-1:0] c_NORM_LAST = CNT_W'(NORM_MOD - 1);
  localparam logic [CNT_W-1:0] c_DBG_LAST  = CNT_W'(DEBUG_MOD - 1);
  localparam logic [FRAM_SIZE-1:0] c_ONE_HOT0 = FRAM_SIZE'(1);

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAM_SIZE-1:0] r_shadow;
  logic                 r_dbg;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  logic [CNT_W-1:0]     w_last;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_next_bit;
  logic                 w_accept;

  // Length is taken from the captured mode, never from the live input.
  assign w_last    = r_dbg ? c_DBG_LAST : c_NORM_LAST;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  // Bit that goes on the line after the current one; a mask keeps every
  // shadow bit in use regardless of the counter width.
  assign w_next_bit = |(r_shadow & (c_ONE_HOT0 << w_cnt_nxt));

  // Ready is held low while reset is applied even though the state is IDLE.
  assign frame_ready = rst_n && (r_state == c_IDLE);
  assign w_accept    = frame_valid && frame_ready;
  assign tx_busy     = (r_state != c_IDLE);
  assign tx_out      = r_tx;
  assign frame_done  = r_done;

  // Frame sequencer: state, bit counter, shadow copy, running parity, line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_dbg    <= 1'b0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shadow <= frame_data;
            r_dbg    <= debug_mode;
            r_cnt    <= '0;
            r_par    <= 1'b0;
            r_tx     <= 1'b0;
            r_state  <= c_START;
          end
        end
        c_START: begin
          if (bit_tick) begin
            r_state <= c_DATA;
            r_tx    <= r_shadow[0];
            r_par   <= r_shadow[0];
          end
        end
        c_DATA: begin
          if (bit_tick) begin
            if (r_cnt == w_last) begin
              // r_par already contains the last bit put on the line.
              r_state <= c_PARITY;
              r_tx    <= r_par;
            end else begin
              r_cnt <= w_cnt_nxt;
              r_tx  <= w_next_bit;
              r_par <= r_par ^ w_next_bit;
            end
          end
        end
        c_PARITY: begin
          if (bit_tick) begin
            r_state <= c_STOP;
            r_tx    <= 1'b1;
          end
        end
        c_STOP: begin
          if (bit_tick) begin
            r_state <= c_IDLE;
            r_tx    <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_puf_frame_tx.sv
//==============================================================================
// Module      : tb_puf_frame_tx
// Description : Directed self-checking bench for puf_frame_tx.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_puf_frame_tx;

  localparam int FS = 160;

  logic          clk;
  logic          rst_n;
  logic          frame_valid;
  logic          frame_ready;
  logic [FS-1:0] frame_data;
  logic          debug_mode;
  logic          bit_tick;
  logic          tx_out;
  logic          tx_busy;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  puf_frame_tx #(
    .FRAM_SIZE (FS),
    .NORM_MOD  (34),
    .DEBUG_MOD (133),
    .CNT_W     (8)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .debug_mode  (debug_mode),
    .bit_tick    (bit_tick),
    .tx_out      (tx_out),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks every line cycle against an expected
  // start/payload/parity/stop sequence. mode 0: valid dropped while busy;
  // mode 1: valid and data scrambled while busy; mode 2: next frame (nd/ndbg)
  // held on the inputs with valid high, returning in the frame_done cycle.
  task automatic run_frame(input logic [FS-1:0] d, input logic dbg, input int per,
                           input int mode, input logic [FS-1:0] nd, input logic ndbg,
                           input string nm);
    int   len;
    int   k;
    int   c;
    logic par;
    logic exp_b;
    len = dbg ? 133 : 34;
    par = 1'b0;
    for (int i = 0; i < len; i++) par ^= d[i];

    frame_data  = d;
    debug_mode  = dbg;
    frame_valid = 1'b1;
    bit_tick    = 1'b1;
    chk($sformatf("%s_ready_at_accept", nm), frame_ready, 1);
    step();
    bit_tick = 1'b0;
    if (mode == 0) frame_valid = 1'b0;
    if (mode == 2) begin
      frame_data = nd;
      debug_mode = ndbg;
    end

    k = 0;
    c = 0;
    while (k < len + 3 && c < (len + 3) * per + 8) begin
      if (k == 0)            exp_b = 1'b0;
      else if (k <= len)     exp_b = d[k-1];
      else if (k == len + 1) exp_b = par;
      else                   exp_b = 1'b1;
      chk($sformatf("%s_tx_bit%0d", nm, k), tx_out, exp_b);
      chk($sformatf("%s_busy_c%0d", nm, c), tx_busy, 1);
      chk($sformatf("%s_ready_c%0d", nm, c), frame_ready, 0);
      chk($sformatf("%s_done_c%0d", nm, c), frame_done, 0);
      bit_tick = ((c % per) == per - 1);
      if (mode == 1) begin
        frame_valid = 1'($urandom_range(0, 1));
        frame_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        debug_mode  = ~debug_mode;
      end
      step();
      if (bit_tick) k++;
      c++;
    end
    chk($sformatf("%s_symbols_sent", nm), k, len + 3);
    bit_tick = 1'b0;
    if (mode == 1) frame_valid = 1'b0;
    chk($sformatf("%s_done_pulse", nm), frame_done, 1);
    chk($sformatf("%s_ready_in_done", nm), frame_ready, 1);
    chk($sformatf("%s_tx_idle", nm), tx_out, 1);
    chk($sformatf("%s_busy_idle", nm), tx_busy, 0);
    if (mode != 2) begin
      step();
      chk($sformatf("%s_done_one_cycle", nm), frame_done, 0);
      chk($sformatf("%s_tx_after", nm), tx_out, 1);
    end
  endtask

  task automatic idle_ticks(input string nm);
    frame_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_tick = 1'b1;
      step();
      chk($sformatf("%s_tx%0d", nm, i), tx_out, 1);
      chk($sformatf("%s_busy%0d", nm, i), tx_busy, 0);
      chk($sformatf("%s_ready%0d", nm, i), frame_ready, 1);
      chk($sformatf("%s_done%0d", nm, i), frame_done, 0);
    end
    bit_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FS-1:0] d_norm;
    logic [FS-1:0] d_all;
    logic [FS-1:0] d_one;
    logic [FS-1:0] d_b1;
    logic [FS-1:0] d_b2;
    logic [FS-1:0] d_rst;
    logic [FS-1:0] d_junk;

    d_norm = FS'(34'h2_5A5A_5A5A);
    d_all  = '1;
    d_one  = FS'(34'h1);
    d_b1   = FS'(34'h1_0F0F_1234);
    d_b2   = FS'(34'h2_8001_7FFE);
    d_rst  = FS'(34'h3_0000_F000);
    d_junk = {126'h2AAA_5555_DEAD_BEEF_0123_4567_89AB_CDEF, 34'h0_C3C3_3C3C};

    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    debug_mode  = 1'b0;
    bit_tick    = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_tx_out", tx_out, 1);
    chk("rst_ready", frame_ready, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", frame_ready, 1);
    step();

    idle_ticks("idle_tick_a");

    run_frame(d_norm, 1'b0, 1, 0, '0, 1'b0, "normal");
    run_frame(d_all, 1'b1, 1, 0, '0, 1'b0, "debug");
    run_frame(d_one, 1'b0, 4, 0, '0, 1'b0, "slow");

    // Back-to-back: second frame waiting with valid high during the first
    run_frame(d_b1, 1'b0, 1, 2, d_b2, 1'b0, "b2b_first");
    run_frame(d_b2, 1'b0, 1, 0, '0, 1'b0, "b2b_second");

    // Reset while payload bit 10 (a zero) is on the line
    frame_data  = d_rst;
    debug_mode  = 1'b0;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    frame_data  = '1;
    bit_tick    = 1'b1;
    repeat (11) step();
    chk("rstmid_bit10_before", tx_out, d_rst[10]);
    chk("rstmid_busy_before", tx_busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_async", tx_out, 1);
    chk("rstmid_busy_async", tx_busy, 0);
    chk("rstmid_ready_async", frame_ready, 0);
    chk("rstmid_done_async", frame_done, 0);
    bit_tick = 1'b0;
    repeat (2) begin
      step();
      chk("rstmid_done_held", frame_done, 0);
      chk("rstmid_tx_held", tx_out, 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_ready_release", frame_ready, 1);
    step();
    chk("rstmid_no_done", frame_done, 0);
    run_frame(d_rst, 1'b0, 1, 0, '0, 1'b0, "after_rst");

    // Inputs scrambled while busy; upper bits beyond the length are junk
    run_frame(d_junk, 1'b0, 2, 1, '0, 1'b0, "noisy");

    idle_ticks("idle_tick_b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
